yutorina_alu: RTL and testbench



---
 rtl/yutorina_alu.sv | 98 +++++++++
 tb/tb_yutorina_alu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/yutorina_alu.sv
// yutorina_alu: 32-bit integer ALU for the Yutorina execute stage.
// Ports:
//   clk, rst   - clock and synchronous active-high reset (registered copies only)
//   op         - 4-bit operation code
//   lhs, rhs   - 32-bit operands
//   out, of    - combinational result and signed-overflow flag
//   out_r, of_r- out/of registered on the rising edge of clk

package yutorina_alu_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SHAM_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOR  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_SLT  = 4'd10,
    OP_SLTU = 4'd11,
    OP_LUI  = 4'd12,
    OP_MOVR = 4'd13
  } alu_op_e;
endpackage

module yutorina_alu
  import yutorina_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] lhs,
  input  logic [DATA_W-1:0] rhs,
  output logic [DATA_W-1:0] out,
  output logic              of,
  output logic [DATA_W-1:0] out_r,
  output logic              of_r
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [SHAM_W-1:0] shamt;

  // Shared arithmetic; carry/borrow out of bit 31 is intentionally dropped.
  assign sum   = lhs + rhs;
  assign diff  = lhs - rhs;
  assign shamt = rhs[SHAM_W-1:0];

  // Result and overflow select; reserved codes fall through to zero.
  always_comb begin
    out = '0;
    of  = 1'b0;
    case (op)
      OP_NOP:  out = lhs;
      OP_ADD: begin
        out = sum;
        of  = (lhs[DATA_W-1] == rhs[DATA_W-1]) && (sum[DATA_W-1] != lhs[DATA_W-1]);
      end
      OP_SUB: begin
        out = diff;
        of  = (lhs[DATA_W-1] != rhs[DATA_W-1]) && (diff[DATA_W-1] != lhs[DATA_W-1]);
      end
      OP_AND:  out = lhs & rhs;
      OP_OR:   out = lhs | rhs;
      OP_XOR:  out = lhs ^ rhs;
      OP_NOR:  out = ~(lhs | rhs);
      OP_SLL:  out = lhs << shamt;
      OP_SRL:  out = lhs >> shamt;
      OP_SRA:  out = DATA_W'($signed(lhs) >>> shamt);
      OP_SLT:  out = DATA_W'($signed(lhs) < $signed(rhs));
      OP_SLTU: out = DATA_W'(lhs < rhs);
      OP_LUI:  out = {rhs[15:0], 16'h0000};
      OP_MOVR: out = rhs;
      default: begin
        out = '0;
        of  = 1'b0;
      end
    endcase
  end

  // Debug copy of the result; reset wins over the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= '0;
      of_r  <= 1'b0;
    end else begin
      out_r <= out;
      of_r  <= of;
    end
  end

endmodule

// File: tb/tb_yutorina_alu.sv
// tb_yutorina_alu: directed self-checking bench for yutorina_alu.
module tb_yutorina_alu;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_LUI  = 4'd12;
  localparam logic [3:0] OP_MOVR = 4'd13;

  logic        clk;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [31:0] out;
  logic        of;
  logic [31:0] out_r;
  logic        of_r;

  int tests;
  int failed;

  yutorina_alu dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .lhs   (lhs),
    .rhs   (rhs),
    .out   (out),
    .of    (of),
    .out_r (out_r),
    .of_r  (of_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load a nonzero overflow result, then reset with the same inputs held.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; op = OP_ADD; lhs = 32'h7FFF_FFFF; rhs = 32'h0000_0001;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_r !== 32'h0) begin
      failed++; $display("FAIL reset_out_r got %h want %h", out_r, 32'h0);
    end
    tests++;
    if (of_r !== 1'b0) begin
      failed++; $display("FAIL reset_of_r got %b want %b", of_r, 1'b0);
    end
    tests++;
    if (out !== 32'h8000_0000) begin
      failed++; $display("FAIL reset_out_comb got %h want %h", out, 32'h8000_0000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [31:0] a  [3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] b  [3] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    logic [31:0] eo [3] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    logic        ef [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      op = OP_ADD; lhs = a[i]; rhs = b[i]; #1;
      tests++;
      if (out !== eo[i] || of !== ef[i]) begin
        failed++;
        $display("FAIL add[%0d] got out=%h of=%b want out=%h of=%b", i, out, of, eo[i], ef[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [31:0] a  [3] = '{32'h8000_0000, 32'h0000_0005, 32'h7FFF_FFFF};
    logic [31:0] b  [3] = '{32'h0000_0001, 32'h0000_0007, 32'hFFFF_FFFF};
    logic [31:0] eo [3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000};
    logic        ef [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      op = OP_SUB; lhs = a[i]; rhs = b[i]; #1;
      tests++;
      if (out !== eo[i] || of !== ef[i]) begin
        failed++;
        $display("FAIL sub[%0d] got out=%h of=%b want out=%h of=%b", i, out, of, eo[i], ef[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [3:0]  o  [8] = '{OP_SLL, OP_SRL, OP_SRA, OP_SLL, OP_SRA, OP_SRL, OP_SRA, OP_SRA};
    logic [31:0] a  [8] = '{32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0,
                            32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    logic [31:0] b  [8] = '{32'hFFFF_FF04, 32'hFFFF_FF04, 32'hFFFF_FF04, 32'hFFFF_FFE0,
                            32'h0000_0000, 32'h0000_001F, 32'h0000_001F, 32'h0000_0001};
    logic [31:0] eo [8] = '{32'h0000_0F00, 32'h0800_000F, 32'hF800_000F, 32'h8000_00F0,
                            32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h2000_0000};
    for (int i = 0; i < 8; i++) begin
      op = o[i]; lhs = a[i]; rhs = b[i]; #1;
      tests++;
      if (out !== eo[i] || of !== 1'b0) begin
        failed++;
        $display("FAIL shift[%0d] op=%0d got out=%h of=%b want out=%h of=0", i, o[i], out, of, eo[i]);
      end
    end
  endtask

  task automatic test_compare();
    logic [3:0]  o  [4] = '{OP_SLT, OP_SLTU, OP_SLT, OP_SLTU};
    logic [31:0] a  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    logic [31:0] b  [4] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] eo [4] = '{32'h1, 32'h0, 32'h0, 32'h1};
    for (int i = 0; i < 4; i++) begin
      op = o[i]; lhs = a[i]; rhs = b[i]; #1;
      tests++;
      if (out !== eo[i]) begin
        failed++;
        $display("FAIL compare[%0d] op=%0d got %h want %h", i, o[i], out, eo[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [3:0]  o  [4] = '{OP_AND, OP_OR, OP_XOR, OP_NOR};
    logic [31:0] eo [4] = '{32'h00F0_0000, 32'hFFF0_00FF, 32'hFF00_00FF, 32'h000F_FF00};
    for (int i = 0; i < 4; i++) begin
      op = o[i]; lhs = 32'hF0F0_0000; rhs = 32'h0FF0_00FF; #1;
      tests++;
      if (out !== eo[i]) begin
        failed++;
        $display("FAIL logic[%0d] op=%0d got %h want %h", i, o[i], out, eo[i]);
      end
    end
    // Operands that would overflow an ADD must not raise of on a logic op.
    op = OP_AND; lhs = 32'h7FFF_FFFF; rhs = 32'h0000_0001; #1;
    tests++;
    if (of !== 1'b0) begin
      failed++; $display("FAIL logic_of got %b want 0", of);
    end
  endtask

  task automatic test_misc();
    logic [3:0]  o  [5] = '{OP_NOP, OP_MOVR, OP_LUI, 4'd14, 4'd15};
    logic [31:0] eo [5] = '{32'h1234_5678, 32'hABCD_1234, 32'h1234_0000, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      op = o[i]; lhs = 32'h1234_5678; rhs = 32'hABCD_1234; #1;
      tests++;
      if (out !== eo[i] || of !== 1'b0) begin
        failed++;
        $display("FAIL misc[%0d] op=%0d got out=%h of=%b want out=%h of=0", i, o[i], out, of, eo[i]);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    op = OP_ADD; lhs = 32'd3; rhs = 32'd4;
    @(posedge clk); #1;
    tests++;
    if (out_r !== 32'd7 || of_r !== 1'b0) begin
      failed++; $display("FAIL reg_load got out_r=%h of_r=%b want 7/0", out_r, of_r);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_r !== 32'd0 || of_r !== 1'b0 || out !== 32'd7) begin
      failed++;
      $display("FAIL reg_rst got out_r=%h of_r=%b out=%h want 0/0/7", out_r, of_r, out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (out_r !== 32'd7) begin
      failed++; $display("FAIL reg_release got %h want 7", out_r);
    end
  endtask

  // New op every cycle; each register sample must hold the previous cycle's result.
  task automatic test_back_to_back();
    logic [3:0]  o  [5] = '{OP_ADD, OP_SUB, 4'd15, OP_SRA, OP_LUI};
    logic [31:0] a  [5] = '{32'h7FFF_FFFF, 32'h0000_0005, 32'hDEAD_BEEF, 32'h8000_00F0, 32'h0};
    logic [31:0] b  [5] = '{32'h0000_0001, 32'h0000_0007, 32'hDEAD_BEEF, 32'h0000_0004, 32'h0000_BEEF};
    logic [31:0] eo [5] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'h0, 32'hF800_000F, 32'hBEEF_0000};
    logic        ef [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op = o[i]; lhs = a[i]; rhs = b[i];
      @(posedge clk); #1;
      tests++;
      if (out_r !== eo[i] || of_r !== ef[i]) begin
        failed++;
        $display("FAIL b2b[%0d] got out_r=%h of_r=%b want out_r=%h of_r=%b", i, out_r, of_r, eo[i], ef[i]);
      end
    end
  endtask

  initial begin
    tests = 0; failed = 0;
    rst = 1'b1; op = OP_NOP; lhs = '0; rhs = '0;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_compare();
    test_logic();
    test_misc();
    test_registered();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
